// File: rtl/cpu_pkg.sv
// Shared CPU definitions: immediate-extension modes, default widths and the
// encoding of the immediate pipe's occupancy state.
package cpu_pkg;

  localparam int IMM_IN_W  = 16;
  localparam int IMM_OUT_W = 32;
  localparam int IMM_TAG_W = 5;

  typedef enum logic [1:0] {
    IMM_SIGN   = 2'd0,
    IMM_ZERO   = 2'd1,
    IMM_UPPER  = 2'd2,
    IMM_BRANCH = 2'd3
  } imm_mode_e;

  // Bit 0 is the OUT valid bit and bit 1 is the SKID valid bit.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'b00,
    ST_ONE   = 2'b01,
    ST_FULL  = 2'b11
  } pipe_state_e;

endpackage

// File: rtl/imm_extend_core.sv
// Combinational immediate extender. It is shared with the single-cycle datapath,
// so it holds no state.
module imm_extend_core
  import cpu_pkg::*;
#(
  parameter int IN_W  = IMM_IN_W,
  parameter int OUT_W = IMM_OUT_W
) (
  input  logic [IN_W-1:0]  imm,
  input  logic [1:0]       mode,
  output logic [OUT_W-1:0] result
);

  localparam int E = OUT_W - IN_W;

  logic [OUT_W-1:0] sext;
  logic [OUT_W-1:0] zext;
  logic [OUT_W-1:0] upper;

  assign sext  = {{E{imm[IN_W-1]}}, imm};
  assign zext  = {{E{1'b0}}, imm};
  assign upper = {imm, {E{1'b0}}};

  // NOTE: result gets a default before the case, so every path assigns it
  // and no latch can be inferred.
  always_comb begin
    result = sext;
    case (imm_mode_e'(mode))
      IMM_SIGN:   result = sext;
      IMM_ZERO:   result = zext;
      IMM_UPPER:  result = upper;
      IMM_BRANCH: result = {sext[OUT_W-3:0], 2'b00};
      default:    result = sext;
    endcase
  end

endmodule

// File: rtl/imm_extend_pipe.sv
// Pipelined immediate-extension stage. It has a registered output, a 2-entry
// skid buffer, a registered ready, and a flush that squashes every held entry.
module imm_extend_pipe
  import cpu_pkg::*;
#(
  parameter int IN_W  = IMM_IN_W,
  parameter int OUT_W = IMM_OUT_W,
  parameter int TAG_W = IMM_TAG_W
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [IN_W-1:0]  data_i,
  input  logic [1:0]       mode_i,
  input  logic [TAG_W-1:0] tag_i,
  input  logic             flush_i,
  output logic             valid_o,
  input  logic             ready_i,
  output logic [OUT_W-1:0] data_o,
  output logic [TAG_W-1:0] tag_o
);

  logic [OUT_W-1:0] ext;

  imm_extend_core #(
    .IN_W (IN_W),
    .OUT_W(OUT_W)
  ) u_core (
    .imm   (data_i),
    .mode  (mode_i),
    .result(ext)
  );

  pipe_state_e      state;
  pipe_state_e      state_n;
  logic             ready_q;
  logic             in_fire;
  logic             out_fire;
  logic             load_out;
  logic             load_skid;
  logic             skid_to_out;
  logic [OUT_W-1:0] out_data;
  logic [OUT_W-1:0] skid_data;
  logic [TAG_W-1:0] out_tag;
  logic [TAG_W-1:0] skid_tag;

  assign in_fire  = valid_i && ready_q;
  assign out_fire = (state != ST_EMPTY) && ready_i;

  always_comb begin
    state_n     = state;
    load_out    = 1'b0;
    load_skid   = 1'b0;
    skid_to_out = 1'b0;
    if (flush_i) begin
      state_n = ST_EMPTY;
    end else begin
      case (state)
        ST_EMPTY: begin
          if (in_fire) begin
            load_out = 1'b1;
            state_n  = ST_ONE;
          end
        end
        ST_ONE: begin
          if (in_fire && ready_i) begin
            load_out = 1'b1;
          end else if (in_fire) begin
            load_skid = 1'b1;
            state_n   = ST_FULL;
          end else if (out_fire) begin
            state_n = ST_EMPTY;
          end
        end
        ST_FULL: begin
          if (out_fire) begin
            skid_to_out = 1'b1;
            state_n     = ST_ONE;
          end
        end
        default: state_n = ST_EMPTY;
      endcase
    end
  end

  // NOTE: all sequential state uses non-blocking assignments, so every
  // register samples values from before the edge.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state   <= ST_EMPTY;
      ready_q <= 1'b1;
    end else begin
      state   <= state_n;
      ready_q <= (state_n != ST_FULL);
    end
  end

  // NOTE: the payload registers are reset too. data_o and tag_o must read
  // zero out of reset, and these registers are only two words wide.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      out_data  <= '0;
      out_tag   <= '0;
      skid_data <= '0;
      skid_tag  <= '0;
    end else begin
      if (load_out) begin
        out_data <= ext;
        out_tag  <= tag_i;
      end else if (skid_to_out) begin
        out_data <= skid_data;
        out_tag  <= skid_tag;
      end
      if (load_skid) begin
        skid_data <= ext;
        skid_tag  <= tag_i;
      end
    end
  end

  assign valid_o = (state != ST_EMPTY);
  assign ready_o = ready_q;
  assign data_o  = out_data;
  assign tag_o   = out_tag;

endmodule

// File: tb/tb_imm_extend_pipe.sv
// Self-checking bench: directed checks on the 16/32 instance and a randomized
// queue-model run on a 12/24 instance.
module tb_imm_extend_pipe;
  import cpu_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  logic        a_valid_i, a_ready_o, a_flush, a_valid_o, a_ready_i;
  logic [15:0] a_data_i;
  logic [1:0]  a_mode;
  logic [4:0]  a_tag_i, a_tag_o;
  logic [31:0] a_data_o;

  logic        b_valid_i, b_ready_o, b_flush, b_valid_o, b_ready_i;
  logic [11:0] b_data_i;
  logic [1:0]  b_mode;
  logic [4:0]  b_tag_i, b_tag_o;
  logic [23:0] b_data_o;

  imm_extend_pipe #(.IN_W(16), .OUT_W(32), .TAG_W(5)) dut_a (
    .clk_i(clk), .rst_i(rst_n), .valid_i(a_valid_i), .ready_o(a_ready_o),
    .data_i(a_data_i), .mode_i(a_mode), .tag_i(a_tag_i), .flush_i(a_flush),
    .valid_o(a_valid_o), .ready_i(a_ready_i), .data_o(a_data_o), .tag_o(a_tag_o)
  );

  imm_extend_pipe #(.IN_W(12), .OUT_W(24), .TAG_W(5)) dut_b (
    .clk_i(clk), .rst_i(rst_n), .valid_i(b_valid_i), .ready_o(b_ready_o),
    .data_i(b_data_i), .mode_i(b_mode), .tag_i(b_tag_i), .flush_i(b_flush),
    .valid_o(b_valid_o), .ready_i(b_ready_i), .data_o(b_data_o), .tag_o(b_tag_o)
  );

  // Reference extension computed arithmetically from the mode rules.
  function automatic logic [31:0] ref_ext(input int unsigned d, input int unsigned m,
                                          input int in_w, input int out_w);
    longint mask;
    longint s;
    longint r;
    mask = (longint'(1) << out_w) - 1;
    s = longint'(d);
    if (((d >> (in_w - 1)) & 1) == 1) s = s - (longint'(1) << in_w);
    case (m)
      0:       r = s;
      1:       r = longint'(d);
      2:       r = longint'(d) << (out_w - in_w);
      default: r = s * 4;
    endcase
    return 32'(r & mask);
  endfunction

  task automatic a_drive(input logic v, input logic [15:0] d, input logic [1:0] m,
                         input logic [4:0] t);
    a_valid_i = v;
    a_data_i  = d;
    a_mode    = m;
    a_tag_i   = t;
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    a_drive(1'b0, 16'h0, 2'd0, 5'd0);
    a_flush = 1'b0; a_ready_i = 1'b1;
    b_valid_i = 1'b0; b_data_i = '0; b_mode = '0; b_tag_i = '0; b_flush = 1'b0; b_ready_i = 1'b1;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (a_valid_o !== 1'b0 || a_ready_o !== 1'b1) begin
      errors++;
      $display("FAIL reset_hs: valid_o=%b ready_o=%b, want 0 1", a_valid_o, a_ready_o);
    end
    checks++;
    if (a_data_o !== 32'h0 || a_tag_o !== 5'd0) begin
      errors++;
      $display("FAIL reset_data: data_o=%h tag_o=%0d, want 0 0", a_data_o, a_tag_o);
    end
    checks++;
    if (b_valid_o !== 1'b0 || b_ready_o !== 1'b1) begin
      errors++;
      $display("FAIL reset_b: valid_o=%b ready_o=%b, want 0 1", b_valid_o, b_ready_o);
    end
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_modes;
    logic [15:0] vd  [7] = '{16'h8001, 16'h8001, 16'h8001, 16'h8001, 16'hFFFF, 16'h7FFF, 16'h1234};
    logic [1:0]  vm  [7] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd3, 2'd0, 2'd2};
    logic [31:0] vex [7] = '{32'hFFFF8001, 32'h00008001, 32'h80010000, 32'hFFFE0004,
                             32'hFFFFFFFC, 32'h00007FFF, 32'h12340000};
    a_ready_i = 1'b1;
    for (int i = 0; i < 7; i++) begin
      a_drive(1'b1, vd[i], vm[i], 5'(i + 1));
      step();
      checks++;
      if (a_valid_o !== 1'b1 || a_data_o !== vex[i] || a_tag_o !== 5'(i + 1) || a_ready_o !== 1'b1) begin
        errors++;
        $display("FAIL modes[%0d]: valid=%b ready=%b data=%h tag=%0d, want 1 1 %h %0d",
                 i, a_valid_o, a_ready_o, a_data_o, a_tag_o, vex[i], i + 1);
      end
    end
    a_valid_i = 1'b0;
    step();
    checks++;
    if (a_valid_o !== 1'b0) begin
      errors++;
      $display("FAIL modes_drain: valid_o=%b, want 0", a_valid_o);
    end
  endtask

  task automatic test_backpressure;
    logic [15:0] d  [3];
    logic [1:0]  m  [3];
    logic [31:0] ex [3];
    for (int i = 0; i < 3; i++) begin
      d[i]  = 16'($urandom);
      m[i]  = 2'($urandom);
      ex[i] = ref_ext(d[i], m[i], 16, 32);
    end
    a_ready_i = 1'b0;
    a_drive(1'b1, d[0], m[0], 5'd1);
    step();
    checks++;
    if (a_valid_o !== 1'b1 || a_tag_o !== 5'd1 || a_ready_o !== 1'b1) begin
      errors++;
      $display("FAIL bp_first: valid=%b tag=%0d ready=%b, want 1 1 1", a_valid_o, a_tag_o, a_ready_o);
    end
    a_drive(1'b1, d[1], m[1], 5'd2);
    step();
    checks++;
    if (a_ready_o !== 1'b0 || a_tag_o !== 5'd1) begin
      errors++;
      $display("FAIL bp_full: ready=%b tag=%0d, want 0 1", a_ready_o, a_tag_o);
    end
    a_drive(1'b1, d[2], m[2], 5'd3);
    for (int k = 0; k < 3; k++) begin
      step();
      checks++;
      if (a_valid_o !== 1'b1 || a_ready_o !== 1'b0 || a_tag_o !== 5'd1 || a_data_o !== ex[0]) begin
        errors++;
        $display("FAIL bp_stall[%0d]: valid=%b ready=%b tag=%0d data=%h, want 1 0 1 %h",
                 k, a_valid_o, a_ready_o, a_tag_o, a_data_o, ex[0]);
      end
    end
    a_ready_i = 1'b1;
    step();
    checks++;
    if (a_valid_o !== 1'b1 || a_tag_o !== 5'd2 || a_data_o !== ex[1] || a_ready_o !== 1'b1) begin
      errors++;
      $display("FAIL bp_tag2: valid=%b tag=%0d data=%h ready=%b, want 1 2 %h 1",
               a_valid_o, a_tag_o, a_data_o, a_ready_o, ex[1]);
    end
    step();
    a_valid_i = 1'b0;
    checks++;
    if (a_valid_o !== 1'b1 || a_tag_o !== 5'd3 || a_data_o !== ex[2]) begin
      errors++;
      $display("FAIL bp_tag3: valid=%b tag=%0d data=%h, want 1 3 %h", a_valid_o, a_tag_o, a_data_o, ex[2]);
    end
    step();
    checks++;
    if (a_valid_o !== 1'b0) begin
      errors++;
      $display("FAIL bp_drain: valid_o=%b, want 0", a_valid_o);
    end
  endtask

  task automatic test_flush;
    a_ready_i = 1'b0;
    a_drive(1'b1, 16'h1111, 2'd0, 5'd4);
    step();
    a_drive(1'b1, 16'h2222, 2'd0, 5'd5);
    step();
    checks++;
    if (a_ready_o !== 1'b0 || a_valid_o !== 1'b1) begin
      errors++;
      $display("FAIL flush_setup: ready=%b valid=%b, want 0 1", a_ready_o, a_valid_o);
    end
    a_drive(1'b1, 16'h3333, 2'd0, 5'd6);
    a_flush = 1'b1;
    step();
    a_flush = 1'b0;
    a_valid_i = 1'b0;
    a_ready_i = 1'b1;
    checks++;
    if (a_valid_o !== 1'b0 || a_ready_o !== 1'b1) begin
      errors++;
      $display("FAIL flush_now: valid=%b ready=%b, want 0 1", a_valid_o, a_ready_o);
    end
    for (int k = 0; k < 3; k++) begin
      step();
      checks++;
      if (a_valid_o !== 1'b0) begin
        errors++;
        $display("FAIL flush_ghost[%0d]: valid=%b tag=%0d, want valid 0", k, a_valid_o, a_tag_o);
      end
    end
    a_drive(1'b1, 16'h0042, 2'd1, 5'd9);
    step();
    a_valid_i = 1'b0;
    checks++;
    if (a_valid_o !== 1'b1 || a_tag_o !== 5'd9 || a_data_o !== 32'h00000042) begin
      errors++;
      $display("FAIL flush_resume: valid=%b tag=%0d data=%h, want 1 9 00000042", a_valid_o, a_tag_o, a_data_o);
    end
    step();
  endtask

  task automatic test_async_reset;
    a_ready_i = 1'b0;
    a_drive(1'b1, 16'h0101, 2'd0, 5'd7);
    step();
    a_drive(1'b1, 16'h0202, 2'd0, 5'd8);
    step();
    a_valid_i = 1'b0;
    checks++;
    if (a_ready_o !== 1'b0 || a_valid_o !== 1'b1) begin
      errors++;
      $display("FAIL arst_setup: ready=%b valid=%b, want 0 1", a_ready_o, a_valid_o);
    end
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (a_valid_o !== 1'b0 || a_ready_o !== 1'b1 || a_data_o !== 32'h0 || a_tag_o !== 5'd0) begin
      errors++;
      $display("FAIL arst_now: valid=%b ready=%b data=%h tag=%0d, want 0 1 0 0",
               a_valid_o, a_ready_o, a_data_o, a_tag_o);
    end
    @(negedge clk);
    rst_n = 1'b1;
    step();
    a_ready_i = 1'b1;
    a_drive(1'b1, 16'hABCD, 2'd2, 5'd10);
    @(negedge clk);
    checks++;
    if (a_valid_o !== 1'b0) begin
      errors++;
      $display("FAIL arst_early: valid=%b, want 0 before the capture edge", a_valid_o);
    end
    step();
    a_valid_i = 1'b0;
    checks++;
    if (a_valid_o !== 1'b1 || a_tag_o !== 5'd10 || a_data_o !== 32'hABCD0000) begin
      errors++;
      $display("FAIL arst_latency: valid=%b tag=%0d data=%h, want 1 10 abcd0000", a_valid_o, a_tag_o, a_data_o);
    end
    step();
  endtask

  typedef struct packed {
    logic [23:0] d;
    logic [4:0]  t;
  } ent_t;

  task automatic test_random;
    ent_t        q[$];
    logic        stalled = 1'b0;
    logic [23:0] prev_d = '0;
    logic [4:0]  prev_t = '0;
    logic        in_fire;
    logic        out_fire;
    for (int c = 0; c < 10000; c++) begin
      b_valid_i = ($urandom_range(0, 3) != 0);
      b_data_i  = 12'($urandom);
      b_mode    = 2'($urandom);
      b_tag_i   = 5'($urandom);
      b_ready_i = ($urandom_range(0, 2) != 0);
      b_flush   = ($urandom_range(0, 63) == 0);
      @(negedge clk);
      checks++;
      if (b_valid_o !== (q.size() > 0)) begin
        errors++;
        $display("FAIL rnd_valid c=%0d: valid_o=%b, want %b", c, b_valid_o, q.size() > 0);
      end
      checks++;
      if (b_ready_o !== (q.size() < 2)) begin
        errors++;
        $display("FAIL rnd_ready c=%0d: ready_o=%b, want %b", c, b_ready_o, q.size() < 2);
      end
      if (q.size() > 0) begin
        checks++;
        if (b_data_o !== q[0].d || b_tag_o !== q[0].t) begin
          errors++;
          $display("FAIL rnd_data c=%0d: data=%h tag=%0d, want %h %0d", c, b_data_o, b_tag_o, q[0].d, q[0].t);
        end
      end
      if (stalled) begin
        checks++;
        if (b_valid_o !== 1'b1 || b_data_o !== prev_d || b_tag_o !== prev_t) begin
          errors++;
          $display("FAIL rnd_stable c=%0d: valid=%b data=%h tag=%0d, want 1 %h %0d",
                   c, b_valid_o, b_data_o, b_tag_o, prev_d, prev_t);
        end
      end
      stalled  = b_valid_o && !b_ready_i && !b_flush;
      prev_d   = b_data_o;
      prev_t   = b_tag_o;
      in_fire  = b_valid_i && (q.size() < 2);
      out_fire = (q.size() > 0) && b_ready_i;
      @(posedge clk);
      if (b_flush) begin
        q.delete();
      end else begin
        if (out_fire) void'(q.pop_front());
        if (in_fire) q.push_back('{d: 24'(ref_ext(b_data_i, b_mode, 12, 24)), t: b_tag_i});
      end
      #1;
    end
    b_valid_i = 1'b0;
    b_flush   = 1'b0;
  endtask

  initial begin
    test_reset();
    test_modes();
    test_backpressure();
    test_flush();
    test_async_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/imm_extend_pipe.md
# imm_extend_pipe

Parametrised, pipelined immediate-extension stage for the decode/execute boundary of the pipelined CPU. It takes an IN_W-bit instruction immediate plus a 2-bit extension mode and delivers an OUT_W-bit operand. The operand can be sign-extended, zero-extended (ORI), upper-placed (LUI), or sign-extended and shifted left by 2 (branch offset). Output is registered behind a valid/ready handshake with a 2-entry skid buffer, so the stage absorbs EX-side stalls without combinational ready paths, and `flush_i` squashes in-flight entries on a branch/hazard flush.

## Interface
- IN_W, 16, immediate input width; must satisfy IN_W >= 2.
- OUT_W, 32, extended output width; must satisfy OUT_W >= IN_W + 2.
- TAG_W, 5, sideband tag (destination register index) carried with each entry.
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_i  in  1  reset, asynchronous, active-low.
- valid_i  in  1  input entry valid.
- ready_o  out  1  stage can accept an entry this cycle; registered.
- data_i  in  IN_W  raw immediate.
- mode_i  in  2  0 = SIGN, 1 = ZERO, 2 = UPPER, 3 = BRANCH.
- tag_i  in  TAG_W  sideband, passed through unchanged.
- flush_i  in  1  synchronous squash of all held entries.
- valid_o  out  1  output entry valid.
- ready_i  in  1  downstream accepts the output entry.
- data_o  out  OUT_W  extended operand.
- tag_o  out  TAG_W  tag of the output entry.

## Operation
- Extension is combinational on input and computed before registering. E = OUT_W - IN_W.
  - SIGN: E copies of data_i[IN_W-1], followed by data_i.
  - ZERO: E zeros, followed by data_i.
  - UPPER: data_i shifted left by E, zero-filled; for 16/32 this is {imm, 16'h0}.
  - BRANCH: the SIGN result shifted left by 2; the top 2 bits are discarded and 2'b00 is appended.
- The input transfer fires when valid_i && ready_o. The output transfer fires when valid_o && ready_i.
- Storage is an output register (OUT) plus a skid register (SKID), each holding {data, tag}.
- State machine, stored as two valid bits:
  - EMPTY: OUT invalid, SKID invalid.
  - ONE: OUT valid, SKID invalid.
  - FULL: OUT valid, SKID valid.
- EMPTY: an input transfer loads OUT and moves to ONE.
- ONE, input only: if ready_i=1, OUT is replaced and the state stays ONE. If ready_i=0, the entry goes to SKID and the state moves to FULL.
- ONE, output only: moves to EMPTY.
- ONE, neither transfer: stays in ONE.
- FULL: ready_o=0 and input is ignored. On an output transfer, SKID moves into OUT and the state moves to ONE.
- Ordering is strictly FIFO; entries are never reordered or duplicated.
- flush_i=1 takes priority over every other event. Next state is EMPTY. An input presented in the same cycle is discarded, even if ready_o=1. An output transfer in the same cycle still counts as consumed downstream.
- When valid_o=0, data_o and tag_o hold their last value; the bench must not check them.

## Timing
- Reset values: valid_o=0, ready_o=1, data_o=0, tag_o=0, state EMPTY.
- Reset asserted mid-operation clears all entries asynchronously, with no partial output.
- Latency is 1 cycle: an entry accepted at edge N appears on data_o after edge N.
- Throughput is 1 entry per cycle while ready_i=1.
- ready_o is a register equal to "state != FULL after this edge". It has no combinational path from ready_i or valid_i.
- After a flush at edge N: valid_o=0 and ready_o=1 from edge N onward.
- Downstream may hold ready_i=0 indefinitely. valid_o, data_o and tag_o must stay stable while valid_o=1 && ready_i=0.

## Structure
- Shared package `cpu_pkg`:
  - Mode encodings IMM_SIGN=0, IMM_ZERO=1, IMM_UPPER=2, IMM_BRANCH=3.
  - Default IN_W/OUT_W constants.
- Sub-module `imm_extend_core`: purely combinational {data_i, mode_i} -> OUT_W result. It is reused by the single-cycle datapath.
- Top level: skid/output registers, valid bits, ready_o register, and flush/reset logic.

## Test plan
- Reset with ready_i=1. Then present 16'h8001 in SIGN, ZERO, UPPER and BRANCH on successive cycles. Required outputs, in order, one per cycle: 32'hFFFF8001, 32'h00008001, 32'h80010000, 32'hFFFE0004.
- BRANCH 16'hFFFF -> 32'hFFFFFFFC. SIGN 16'h7FFF -> 32'h00007FFF. UPPER 16'h1234 -> 32'h12340000.
- Backpressure:
  - Hold ready_i=0 and stream tags 1, 2, 3. Tags 1 and 2 are accepted; ready_o=0 one cycle after tag 2 is accepted; tag 3 is held at the input.
  - Release ready_i. Tags emerge in order 1, 2, 3 with no gaps or loss.
- Flush in state FULL, with valid_i=1 in the same cycle. Next cycle: valid_o=0, ready_o=1, and the flushed input never appears.
- Assert rst_i=0 asynchronously (between clock edges) while FULL. valid_o drops immediately. After release, a new entry has 1-cycle latency.
- Random valid_i/ready_i for 10k cycles at IN_W=12, OUT_W=24, checked against a reference queue model. No loss, no duplication, outputs in order, output stable while stalled.
